prince_ti_round_ctrl: RTL and testbench

Round controller for the 4-share threshold-implementation PRINCE encryption core. Sequences the shared datapath (key whitening, affine/linear layers, pipelined masked S-box) through the 12 S-layer passes of one PRINCE encryption. Gates each pass on availability of fresh masking randomness. Exposes a start/ready and done/ack handshake to the surrounding wrapper.

---
 rtl/prince_ti_round_ctrl_pkg.sv | 40 ++++
 rtl/prince_pass_counter.sv | 40 ++++
 rtl/prince_ti_round_ctrl.sv | 102 ++++++++++
 tb/tb_prince_ti_round_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prince_ti_round_ctrl_pkg.sv
// rtl/prince_ti_round_ctrl_pkg.sv - shared constants, state/phase encodings and pass decode helpers
package prince_ti_round_ctrl_pkg;

    localparam int NUM_PASSES     = 12;
    localparam int FIRST_MID_PASS = 5;
    localparam int FIRST_INV_PASS = 6;
    localparam int INV_PHASE_PASS = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_FWD = 2'd0,
        PH_MID = 2'd1,
        PH_INV = 2'd2
    } phase_t;

    function automatic logic [1:0] phase_of(input logic [3:0] pass);
        logic [1:0] ph;
        if (pass < 4'(FIRST_MID_PASS)) begin
            ph = PH_FWD;
        end else if (pass < 4'(INV_PHASE_PASS)) begin
            ph = PH_MID;
        end else begin
            ph = PH_INV;
        end
        return ph;
    endfunction

    // The middle phase straddles the S-box direction flip: pass 5 is forward, pass 6 inverse.
    function automatic logic sbox_inv_of(input logic [3:0] pass);
        return pass >= 4'(FIRST_INV_PASS);
    endfunction

endpackage

// File: rtl/prince_pass_counter.sv
// rtl/prince_pass_counter.sv - S-box stage and pass counters with enable/clear and terminal flags
module prince_pass_counter
    import prince_ti_round_ctrl_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] stage,
    output logic [3:0] pass,
    output logic       last_stage,
    output logic       last_pass
);

    assign last_stage = (stage == 2'(STAGES - 1));
    assign last_pass  = (pass == 4'(NUM_PASSES - 1));

    // The pass index holds at its terminal value so the final whitening still sees pass 11.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
            pass  <= '0;
        end else if (clr) begin
            stage <= '0;
            pass  <= '0;
        end else if (en) begin
            if (last_stage) begin
                stage <= '0;
                if (!last_pass) begin
                    pass <= pass + 4'd1;
                end
            end else begin
                stage <= stage + 2'd1;
            end
        end
    end

endmodule

// File: rtl/prince_ti_round_ctrl.sv
// rtl/prince_ti_round_ctrl.sv - PRINCE TI round sequencer; optional abort via PRINCE_CTRL_ABORT_EN
module prince_ti_round_ctrl
    import prince_ti_round_ctrl_pkg::*;
#(
    parameter int SBOX_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       ready_o,
    input  logic       rnd_valid_i,
    output logic       rnd_req_o,
    output logic       load_o,
    output logic       state_en_o,
    output logic [3:0] round_o,
    output logic [1:0] phase_o,
    output logic       sbox_inv_o,
    output logic [1:0] stage_o,
    output logic       final_o,
    output logic       done_o,
`ifdef PRINCE_CTRL_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic       ack_i
);

    state_t     state;
    state_t     nxt;
    logic       dp_valid;
    logic       abort;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] stage;
    logic [3:0] pass;
    logic       last_stage;
    logic       last_pass;

`ifdef PRINCE_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // A pass only advances when fresh masks are present, so a stall freezes the whole datapath.
    assign cnt_en     = rnd_req_o & rnd_valid_i;
    assign state_en_o = cnt_en & last_stage;
    assign cnt_clr    = (state == S_FINAL) | (abort & (state != S_IDLE));

    prince_pass_counter #(
        .STAGES (SBOX_STAGES)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .stage      (stage),
        .pass       (pass),
        .last_stage (last_stage),
        .last_pass  (last_pass)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start_i) nxt = S_LOAD;
            S_LOAD:  nxt = S_RUN;
            S_RUN:   if (cnt_en && last_stage && last_pass) nxt = S_FINAL;
            S_FINAL: nxt = S_DONE;
            S_DONE:  if (ack_i) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready_o   <= 1'b1;
            load_o    <= 1'b0;
            rnd_req_o <= 1'b0;
            final_o   <= 1'b0;
            done_o    <= 1'b0;
            dp_valid  <= 1'b0;
        end else begin
            state     <= nxt;
            ready_o   <= (nxt == S_IDLE);
            load_o    <= (nxt == S_LOAD);
            rnd_req_o <= (nxt == S_RUN);
            final_o   <= (nxt == S_FINAL);
            done_o    <= (nxt == S_DONE);
            dp_valid  <= (nxt == S_LOAD) || (nxt == S_RUN) || (nxt == S_FINAL);
        end
    end

    assign round_o    = dp_valid ? pass : 4'd0;
    assign stage_o    = dp_valid ? stage : 2'd0;
    assign phase_o    = dp_valid ? phase_of(pass) : 2'd0;
    assign sbox_inv_o = dp_valid & sbox_inv_of(pass);

endmodule

// File: tb/tb_prince_ti_round_ctrl.sv
// tb/tb_prince_ti_round_ctrl.sv - directed self-checking bench for prince_ti_round_ctrl
module tb_prince_ti_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       rnd_valid_i = 1'b1;
    logic       ack_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       ready_o, rnd_req_o, load_o, state_en_o, sbox_inv_o, final_o, done_o;
    logic [3:0] round_o;
    logic [1:0] phase_o, stage_o;

    int total = 0;
    int bad = 0;
    int ph_tab [12] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2};
    int k, p, n;

    always #5 clk = ~clk;

    prince_ti_round_ctrl #(.SBOX_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .ready_o     (ready_o),
        .rnd_valid_i (rnd_valid_i),
        .rnd_req_o   (rnd_req_o),
        .load_o      (load_o),
        .state_en_o  (state_en_o),
        .round_o     (round_o),
        .phase_o     (phase_o),
        .sbox_inv_o  (sbox_inv_o),
        .stage_o     (stage_o),
        .final_o     (final_o),
        .done_o      (done_o),
`ifdef PRINCE_CTRL_ABORT_EN
        .abort_i     (abort_i),
`endif
        .ack_i       (ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and returns cycles from acceptance edge to first done_o, plus state_en pulses.
    task automatic run_count(input int s_round, input int s_stage, input int nstall,
                             output int cycles, output int pulses);
        int stalls;
        stalls = 0;
        pulses = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cycles = 1;
        while (!done_o && cycles < 200) begin
            if (rnd_req_o && round_o == 4'(s_round) && stage_o == 2'(s_stage) && stalls < nstall) begin
                rnd_valid_i = 1'b0;
                stalls++;
            end else begin
                rnd_valid_i = 1'b1;
            end
            #1;
            if (!rnd_valid_i) begin
                chk("stall_state_en", state_en_o, 0);
                chk("stall_round", round_o, s_round);
                chk("stall_stage", stage_o, s_stage);
            end
            pulses += int'(state_en_o);
            tick();
            cycles++;
        end
        rnd_valid_i = 1'b1;
        chk("run_timeout", cycles < 200, 1);
    endtask

    initial begin
        #12;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_round", round_o, 0);
        chk("rst_rnd_req", rnd_req_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Nominal run with full decode check and a stray start during RUN
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("load", load_o, 1);
        chk("load_round", round_o, 0);
        chk("load_stage", stage_o, 0);
        chk("load_ready", ready_o, 0);
        for (int i = 1; i <= 24; i++) begin
            start_i = (i == 5);
            tick();
            chk("run_rnd_req", rnd_req_o, 1);
            chk("run_round", round_o, (i - 1) / 2);
            chk("run_stage", stage_o, (i - 1) % 2);
            chk("run_phase", phase_o, ph_tab[(i - 1) / 2]);
            chk("run_sbox_inv", sbox_inv_o, ((i - 1) / 2) >= 6);
            chk("run_state_en", state_en_o, (i % 2) == 0);
        end
        start_i = 1'b0;
        tick();
        chk("final", final_o, 1);
        chk("final_round", round_o, 11);
        chk("final_rnd_req", rnd_req_o, 0);
        tick();
        chk("done", done_o, 1);
        chk("done_round", round_o, 0);
        chk("done_ready", ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_hold", done_o, 1);
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ack_ready", ready_o, 1);
        chk("ack_done", done_o, 0);
        tick();
        chk("single_done", done_o, 0);
        chk("no_restart", load_o, 0);

        // Three-cycle randomness stall in pass 7 stage 1
        run_count(7, 1, 3, k, p);
        chk("stall_latency", k, 30);
        chk("stall_pulses", p, 12);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("stall_ack_ready", ready_o, 1);

        // Asynchronous reset in pass 4
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (round_o != 4'd4 && n < 50) begin
            tick();
            n++;
        end
        chk("reach_pass4", n < 50, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready", ready_o, 1);
        chk("async_rnd_req", rnd_req_o, 0);
        chk("async_round", round_o, 0);
        chk("async_state_en", state_en_o, 0);
        chk("async_done", done_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", ready_o, 1);
        run_count(15, 0, 0, k, p);
        chk("post_rst_latency", k, 27);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("post_rst_ack", ready_o, 1);

`ifdef PRINCE_CTRL_ABORT_EN
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (round_o != 4'd3 && n < 50) begin
            tick();
            n++;
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_done", done_o, 0);
        chk("abort_round", round_o, 0);
        tick();
        chk("abort_stay_idle", ready_o, 1);
        chk("abort_no_done", done_o, 0);
        run_count(15, 0, 0, k, p);
        chk("abort_rerun_latency", k, 27);
        ack_i = 1'b1;
        abort_i = 1'b1;
        tick();
        ack_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_ack_ready", ready_o, 1);
        chk("abort_ack_done", done_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
